// File: rtl/lms_step_controller.sv
// lms_step_controller
//   Step-size controller for an LMS adaptive filter. It squares the filter
//   error, averages the squares over fixed windows of 2**LOG2_WIN accepted
//   samples to estimate the MSE, and runs a convergence state machine. The
//   state machine picks the step size fed back to the filter:
//   mu_acq (ACQUIRE), mu_track (TRACK) or 0 (DIVERGED).
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_valid     : qualifies error; cycles with in_valid=0 are ignored
//   error        : signed Q(WIDTH-FRAC).FRAC filter error
//   mu_acq       : step size used while acquiring
//   mu_track     : step size used while tracking
//   conv_thresh  : unsigned MSE threshold for convergence (strictly below)
//   div_thresh   : unsigned MSE threshold for divergence (strictly above)
//   restart      : one-cycle pulse, re-arms to ACQUIRE and drops the partial window
//   step_size    : combinational mux of the current state
//   mse          : unsigned MSE of the last completed window, same Q format as error
//   mse_valid    : one-cycle pulse when mse updates
//   converged    : high while in TRACK
//   diverged     : high while in DIVERGED
//
// Handshake: there is no backpressure. A sample is accepted on every rising
//   edge where in_valid=1 and restart=0. mse_valid is a one-cycle strobe that
//   rises two cycles after the last sample of a window is accepted.
//   converged and diverged decode the registered state, so
//   {diverged, converged} is the state: 00 ACQUIRE, 01 TRACK, 10 DIVERGED.
module lms_step_controller #(
  parameter int WIDTH        = 16,
  parameter int FRAC         = 8,
  parameter int LOG2_WIN     = 4,
  parameter int CONV_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] error,
  input  logic [WIDTH-1:0] mu_acq,
  input  logic [WIDTH-1:0] mu_track,
  input  logic [WIDTH-1:0] conv_thresh,
  input  logic [WIDTH-1:0] div_thresh,
  input  logic             restart,
  output logic [WIDTH-1:0] step_size,
  output logic [WIDTH-1:0] mse,
  output logic             mse_valid,
  output logic             converged,
  output logic             diverged
);

  localparam int SQ_W     = 2 * WIDTH;
  localparam int ACC_W    = SQ_W + LOG2_WIN;
  localparam int SHIFT    = LOG2_WIN + FRAC;
  // Width of total >> SHIFT. It is wider than WIDTH whenever the error
  // format has at least one integer bit, so the saturation check below is
  // always meaningful.
  localparam int QUOT_W   = ACC_W - SHIFT;
  localparam int STREAK_W = $clog2(CONV_WINDOWS + 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_TRACK    = 2'd1,
    ST_DIVERGED = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [SQ_W-1:0]     sq_q,        sq_d;
  logic                sq_vld_q,    sq_vld_d;
  logic                sq_last_q,   sq_last_d;
  logic [LOG2_WIN-1:0] cnt_q,       cnt_d;
  logic [ACC_W-1:0]    acc_q,       acc_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic [WIDTH-1:0]    mse_q,       mse_d;
  logic                mse_valid_q, mse_valid_d;

  logic signed [SQ_W-1:0] product;
  logic [ACC_W-1:0]       total;
  logic [QUOT_W-1:0]      quot;
  logic [WIDTH-1:0]       mse_new;
  logic [STREAK_W-1:0]    streak_inc;

  always_comb begin
    // A square is never negative, so the signed product is reused as an
    // unsigned value with 2*FRAC fractional bits.
    product    = $signed(error) * $signed(error);
    total      = acc_q + ACC_W'(sq_q);
    quot       = total[ACC_W-1:SHIFT];
    mse_new    = (|quot[QUOT_W-1:WIDTH]) ? {WIDTH{1'b1}} : quot[WIDTH-1:0];
    streak_inc = streak_q + 1'b1;

    state_d     = state_q;
    sq_d        = sq_q;
    sq_vld_d    = 1'b0;
    sq_last_d   = sq_last_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    streak_d    = streak_q;
    mse_d       = mse_q;
    mse_valid_d = 1'b0;

    // Stage 1: square accepted samples and tag the last one of the window.
    if (in_valid) begin
      sq_d      = product;
      sq_vld_d  = 1'b1;
      sq_last_d = (cnt_q == {LOG2_WIN{1'b1}});
      cnt_d     = cnt_q + 1'b1;
    end

    // Stage 2: accumulate; on the last square, close the window and step
    // the state machine with the fresh MSE.
    if (sq_vld_q) begin
      if (sq_last_q) begin
        acc_d       = '0;
        mse_d       = mse_new;
        mse_valid_d = 1'b1;
        case (state_q)
          ST_ACQUIRE: begin
            if (mse_new > div_thresh) begin
              state_d = ST_DIVERGED;
            end else if (mse_new < conv_thresh) begin
              if (streak_inc == STREAK_W'(CONV_WINDOWS)) begin
                state_d  = ST_TRACK;
                streak_d = '0;
              end else begin
                streak_d = streak_inc;
              end
            end else begin
              streak_d = '0;
            end
          end
          ST_TRACK: begin
            if (mse_new > div_thresh) begin
              state_d = ST_DIVERGED;
            end else if (mse_new >= conv_thresh) begin
              state_d  = ST_ACQUIRE;
              streak_d = '0;
            end
          end
          default: state_d = ST_DIVERGED;
        endcase
      end else begin
        acc_d = total;
      end
    end

    // Restart drops the partial window, including any square still in
    // stage 1 and any sample offered this cycle. mse is left untouched.
    if (restart) begin
      state_d     = ST_ACQUIRE;
      sq_vld_d    = 1'b0;
      cnt_d       = '0;
      acc_d       = '0;
      streak_d    = '0;
      mse_d       = mse_q;
      mse_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACQUIRE;
      sq_q        <= '0;
      sq_vld_q    <= 1'b0;
      sq_last_q   <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      streak_q    <= '0;
      mse_q       <= '0;
      mse_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sq_q        <= sq_d;
      sq_vld_q    <= sq_vld_d;
      sq_last_q   <= sq_last_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      streak_q    <= streak_d;
      mse_q       <= mse_d;
      mse_valid_q <= mse_valid_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_ACQUIRE: step_size = mu_acq;
      ST_TRACK:   step_size = mu_track;
      default:    step_size = '0;
    endcase
  end

  assign mse       = mse_q;
  assign mse_valid = mse_valid_q;
  assign converged = (state_q == ST_TRACK);
  assign diverged  = (state_q == ST_DIVERGED);

endmodule

// File: doc/lms_step_controller.md
Name: lms_step_controller

Overview:
- Downstream companion of the LMS adaptive filter: consumes its `error` output and drives its `step_size` input.
- Estimates mean-squared error (MSE) over fixed windows of valid samples.
- Runs a convergence state machine that selects a large acquisition step, a small tracking step, or a frozen step of zero.
- Exposes MSE and status flags for software and for the test bench.

Parameters:
- WIDTH, 16, width of error, step size, thresholds and MSE.
- FRAC, 8, fractional bits of error, step size, thresholds and MSE. Error is signed Q(WIDTH-FRAC).FRAC.
- LOG2_WIN, 4, log2 of the number of valid samples per MSE window.
- CONV_WINDOWS, 4, number of consecutive windows below conv_thresh required to enter TRACK.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  error sample qualifier.
- error  in  WIDTH  signed filter error (desired - dout).
- mu_acq  in  WIDTH  step size used in ACQUIRE.
- mu_track  in  WIDTH  step size used in TRACK.
- conv_thresh  in  WIDTH  unsigned MSE convergence threshold.
- div_thresh  in  WIDTH  unsigned MSE divergence threshold.
- restart  in  1  one-cycle pulse that leaves DIVERGED, or re-arms from any state.
- step_size  out  WIDTH  step size to the filter.
- mse  out  WIDTH  unsigned MSE of the last completed window, same Q format as error.
- mse_valid  out  1  one-cycle pulse when mse updates.
- converged  out  1  high while in TRACK.
- diverged  out  1  high while in DIVERGED.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - state=ACQUIRE; mse=0; mse_valid=0; accumulator, sample counter, streak counter and square stage cleared.
  - converged=0; diverged=0.
- step_size is a combinational mux on state: ACQUIRE->mu_acq, TRACK->mu_track, DIVERGED->0. After reset, step_size=mu_acq.
- Pipeline:
  - Stage 1 registers sq = error*error, unsigned 2*WIDTH bits, 2*FRAC fractional bits, only when in_valid=1.
  - Stage 2 adds sq into an accumulator of 2*WIDTH+LOG2_WIN bits. This width cannot overflow; no wrap is permitted.
- Window:
  - A sample counter counts accepted samples modulo 2^LOG2_WIN. Cycles with in_valid=0 are ignored, so bubbles are allowed.
  - When the last square of a window enters stage 2, total = acc + sq.
  - mse = total >> (LOG2_WIN+FRAC), saturated to 2^WIDTH-1.
  - At that edge, mse_valid pulses, mse and state update, and the accumulator reloads to 0.
- Latency: if the last sample of a window is accepted in cycle t, then mse_valid=1, the new mse and the new state are all visible in cycle t+2.
- State transitions are evaluated only on window completion, using the new MSE value m:
  - ACQUIRE:
    - m > div_thresh -> DIVERGED.
    - else m < conv_thresh -> streak++; if streak reaches CONV_WINDOWS -> TRACK, streak=0.
    - else streak=0.
  - TRACK:
    - m > div_thresh -> DIVERGED.
    - else m >= conv_thresh -> ACQUIRE, streak=0.
    - else stay.
  - DIVERGED: stays regardless of m. MSE windows keep computing and mse_valid keeps pulsing.
- restart=1 at an edge, from any state:
  - state=ACQUIRE; accumulator, sample counter, streak and stage-1 valid cleared.
  - Any in_valid sample in the same cycle is discarded.
  - mse holds its last value; no mse_valid pulse.
- rst has priority over restart. Both are synchronous and take effect mid-window, discarding partial windows.
- Thresholds and mu inputs are sampled live (not latched). Changes take effect at the next window completion, or immediately on step_size.

Test Plan:
1. Reset check: assert rst 2 cycles with mu_acq=0x0040 -> state ACQUIRE, mse=0x0000, mse_valid=0, converged=0, diverged=0, step_size=0x0040.
2. Basic window: error=0x0100 (1.0) for 16 consecutive valid cycles -> single mse_valid pulse 2 cycles after the 16th sample, mse=0x0100. Repeat with error=0xFF80 (-0.5) -> mse=0x0040.
3. Convergence: conv_thresh=0x0010, div_thresh=0x0400, mu_track=0x0004.
   - error=0x0020 for 64 samples (mse=0x0004) -> converged=1 and step_size=0x0004 at the 4th mse_valid.
   - Variant: 3 good windows, then one window at error=0x0100 -> streak resets and converged stays 0.
4. Divergence/saturation: error=0x8000 for 16 samples -> mse=0xFFFF (saturated, no wrap), diverged=1, step_size=0. Pulse restart -> ACQUIRE, step_size=mu_acq.
5. Bubbles: 16 valid samples of 0x0100 interleaved with random in_valid=0 cycles -> mse=0x0100, pulse 2 cycles after the 16th valid sample.
6. Mid-window restart: 10 samples, then restart, then 16 samples of 0x0080 -> only one mse_valid, mse=0x0040. In TRACK, a window with mse=0x0020 (≥conv_thresh) -> returns to ACQUIRE, converged=0.
